// File: rtl/tub_pkg.sv
// tub_pkg
// Shared definitions for the tube text scroller:
//   - tub_state_e   : scroller FSM states
//   - CH_*          : special character codes (blank, dash, underscore)
//   - SEG_*         : special segment patterns
//   - SEG_TABLE     : 64-entry character code -> segment lookup
//   - char_to_seg() : table lookup helper
// Segment bit order is {a,b,c,d,e,f,g,dp}, active-high, dp always 0.
package tub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STATIC,
        ST_SCROLL
    } tub_state_e;

    localparam int CH_BLANK = 36;
    localparam int CH_DASH  = 37;
    localparam int CH_UNDER = 38;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h02;
    localparam logic [7:0] SEG_UNDER = 8'h10;

    // Codes 0-9 digits, 10-35 letters A-Z (best-effort seven-segment
    // shapes), 36 blank, 37 dash, 38 underscore, 39-63 blank.
    localparam logic [7:0] SEG_TABLE [64] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6,
        8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E, 8'hBC, 8'h6E,
        8'h0C, 8'h78, 8'h6E, 8'h1C, 8'hEC, 8'h2A, 8'h3A, 8'hCE,
        8'hE6, 8'h0A, 8'hB6, 8'h1E, 8'h7C, 8'h38, 8'h3C, 8'h6E,
        8'h76, 8'hDA,
        SEG_BLANK, SEG_DASH, SEG_UNDER,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00
    };

    function automatic logic [7:0] char_to_seg(input logic [5:0] code);
        return SEG_TABLE[code];
    endfunction

endpackage

// File: rtl/tub_text_scroller_if.sv
// tub_text_scroller_if
// Character write port of the text scroller.
//   wr_valid : character write request (master -> slave)
//   wr_char  : character code         (master -> slave)
//   commit   : end of message          (master -> slave)
//   wr_ready : slave accepts a character this cycle (slave -> master)
// A character transfers on a rising edge with wr_valid && wr_ready.
interface tub_text_scroller_if #(
    parameter int CHAR_W = 6
);
    logic              wr_valid;
    logic              wr_ready;
    logic [CHAR_W-1:0] wr_char;
    logic              commit;

    modport master (
        output wr_valid,
        output wr_char,
        output commit,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_char,
        input  commit,
        output wr_ready
    );
endinterface

// File: rtl/tub_char_decoder.sv
// tub_char_decoder
// Combinational character code -> segment pattern lookup.
//   char_code : CHAR_W-bit character code
//   seg       : NUM_TUBS-bit segment pattern {a,b,c,d,e,f,g,dp}
// Codes outside the 64-entry table decode to blank.
module tub_char_decoder
    import tub_pkg::*;
#(
    parameter int CHAR_W   = 6,
    parameter int NUM_TUBS = 8
) (
    input  logic [CHAR_W-1:0]   char_code,
    output logic [NUM_TUBS-1:0] seg
);

    always_comb begin
        seg = NUM_TUBS'(SEG_BLANK);
        if (int'(char_code) < 64) begin
            seg = NUM_TUBS'(char_to_seg(6'(char_code)));
        end
    end

endmodule

// File: rtl/tub_text_scroller.sv
// tub_text_scroller
// Message buffer and scroll engine for the eight-digit tube display.
// Characters arrive over the write interface and are stored in order;
// commit starts display: left-aligned static text for up to eight
// characters, otherwise a right-to-left scroll over the message followed
// by eight blanks.
// Ports:
//   sys_clk      : system clock, all logic on rising edge
//   rst_n        : synchronous active-low reset
//   clr          : discard message and return to idle
//   wr           : write interface (slave modport)
//   msg_len      : characters currently stored
//   showing      : high while text is displayed
//   data7..data0 : registered segment patterns, data7 = leftmost digit
// Optional feature: define TUB_BLINK_EN to add the blink input and the
// BLINK_DIV parameter (blanks the display on alternate BLINK_DIV periods).
module tub_text_scroller
    import tub_pkg::*;
#(
    parameter int CHAR_W     = 6,
    parameter int MSG_DEPTH  = 32,
    parameter int SCROLL_DIV = 25_000_000,
    parameter int NUM_TUBS   = 8
`ifdef TUB_BLINK_EN
    ,
    parameter int BLINK_DIV  = 50_000_000
`endif
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       clr,
`ifdef TUB_BLINK_EN
    input  logic                       blink,
`endif
    tub_text_scroller_if.slave         wr,
    output logic [$clog2(MSG_DEPTH):0] msg_len,
    output logic                       showing,
    output logic [NUM_TUBS-1:0]        data7,
    output logic [NUM_TUBS-1:0]        data6,
    output logic [NUM_TUBS-1:0]        data5,
    output logic [NUM_TUBS-1:0]        data4,
    output logic [NUM_TUBS-1:0]        data3,
    output logic [NUM_TUBS-1:0]        data2,
    output logic [NUM_TUBS-1:0]        data1,
    output logic [NUM_TUBS-1:0]        data0
);

    localparam int NUM_DIGITS = 8;
    localparam int LEN_W      = $clog2(MSG_DEPTH) + 1;
    localparam int IDX_W      = $clog2(MSG_DEPTH);
    // Positions range over message + eight trailing blanks + digit index.
    localparam int POS_W      = LEN_W + 1;
    localparam int STEP_W     = $clog2(SCROLL_DIV);

    tub_state_e          state_q;
    tub_state_e          state_d;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    len_inc;
    logic [LEN_W-1:0]    len_after;
    logic [POS_W-1:0]    offset_q;
    logic [POS_W-1:0]    virt_last;
    logic [STEP_W-1:0]   step_q;
    logic [CHAR_W-1:0]   msg_buf    [MSG_DEPTH];
    logic [CHAR_W-1:0]   digit_char [NUM_DIGITS];
    logic [NUM_TUBS-1:0] digit_seg  [NUM_DIGITS];
    logic [NUM_TUBS-1:0] data_q     [NUM_DIGITS];
    logic                xfer;
    logic                commit_ok;
    logic                shown;
    logic                hide;

    // wr_ready is held low while reset is asserted so no transfer can be
    // seen during reset even though the state register is already IDLE.
    assign wr.wr_ready = rst_n &&
                         ((state_q == ST_IDLE) ||
                          ((state_q == ST_LOAD) && (len_q < LEN_W'(MSG_DEPTH))));

    // clr wins over a concurrent write and commit.
    assign xfer      = wr.wr_valid && wr.wr_ready && !clr;
    assign commit_ok = (state_q == ST_LOAD) && wr.commit && !clr;
    assign len_inc   = len_q + LEN_W'(1);
    assign len_after = xfer ? len_inc : len_q;
    assign virt_last = POS_W'(len_q) + POS_W'(NUM_DIGITS - 1);
    assign shown     = (state_q == ST_STATIC) || (state_q == ST_SCROLL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (commit_ok) begin
                    state_d = (len_after <= LEN_W'(NUM_DIGITS)) ? ST_STATIC : ST_SCROLL;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
        if (clr) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Length, scroll offset and step prescaler.
    always_ff @(posedge sys_clk) begin
        if (!rst_n || clr) begin
            len_q    <= '0;
            offset_q <= '0;
            step_q   <= '0;
        end else begin
            if (xfer) begin
                len_q <= len_inc;
            end
            if (commit_ok) begin
                offset_q <= '0;
                step_q   <= '0;
            end else if (state_q == ST_SCROLL) begin
                if (step_q == STEP_W'(SCROLL_DIV - 1)) begin
                    step_q   <= '0;
                    offset_q <= (offset_q == virt_last) ? '0 : offset_q + POS_W'(1);
                end else begin
                    step_q <= step_q + STEP_W'(1);
                end
            end
        end
    end

    // Message storage needs no reset: only entries below len_q are shown.
    always_ff @(posedge sys_clk) begin
        if (xfer) begin
            msg_buf[len_q[IDX_W-1:0]] <= wr.wr_char;
        end
    end

`ifdef TUB_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_off;

    // Blink phase restarts visible whenever blink drops or text is not shown.
    always_ff @(posedge sys_clk) begin
        if (!rst_n || !blink || !shown) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    assign hide = blink_off;
`else
    assign hide = 1'b0;
`endif

    // Character selection per digit; k = 0 is the leftmost digit.
    // In scroll mode the position wraps once over the virtual length.
    always_comb begin
        logic [POS_W-1:0] pos;
        pos = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digit_char[k] = CHAR_W'(CH_BLANK);
            if (!hide && (state_q == ST_STATIC)) begin
                if (POS_W'(k) < POS_W'(len_q)) begin
                    digit_char[k] = msg_buf[IDX_W'(k)];
                end
            end else if (!hide && (state_q == ST_SCROLL)) begin
                pos = offset_q + POS_W'(k);
                if (pos > virt_last) begin
                    pos = pos - virt_last - POS_W'(1);
                end
                if (pos < POS_W'(len_q)) begin
                    digit_char[k] = msg_buf[pos[IDX_W-1:0]];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        tub_char_decoder #(
            .CHAR_W   (CHAR_W),
            .NUM_TUBS (NUM_TUBS)
        ) u_dec (
            .char_code (digit_char[g]),
            .seg       (digit_seg[g])
        );
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            data_q <= digit_seg;
        end
    end

    assign msg_len = len_q;
    assign showing = rst_n && shown;
    assign data7   = data_q[0];
    assign data6   = data_q[1];
    assign data5   = data_q[2];
    assign data4   = data_q[3];
    assign data3   = data_q[4];
    assign data2   = data_q[5];
    assign data1   = data_q[6];
    assign data0   = data_q[7];

endmodule

// File: doc/tub_text_scroller.md
# tub_text_scroller

Message buffer and scroll engine feeding the eight-digit tube display driver. Accepts a character stream over a valid/ready write port, stores up to MSG_DEPTH characters, and presents eight registered segment patterns on data7..data0, left-aligned when the message fits and scrolling right-to-left when it does not. Sits between the organ's UI/song-title logic and the display driver, which consumes data7..data0 unchanged.

## Interface

- CHAR_W, 6: character code width.
- MSG_DEPTH, 32: buffer capacity in characters (power of two, ≥ 8).
- SCROLL_DIV, 25_000_000: sys_clk cycles per scroll step (≥ 2).
- NUM_TUBS, 8: segment pattern width.
- sys_clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- clr  in  1  discard message and return to IDLE.
- wr_valid  in  1  character write request.
- wr_ready  out  1  block accepts a character this cycle.
- wr_char  in  CHAR_W  character code.
- commit  in  1  end of message; start display.
- msg_len  out  $clog2(MSG_DEPTH)+1  characters currently stored.
- showing  out  1  high in STATIC or SCROLL.
- data7..data0  out  NUM_TUBS each  segment pattern, data7 = leftmost digit.

## Operation

- Character codes: 0–9 digits, 10–35 letters A–Z, 36 blank, 37 dash, 38 underscore, 39–63 blank.
- Segment encoding: active-high, {a,b,c,d,e,f,g,dp}; '0' = 8'hFC, '1' = 8'h60, 'A' = 8'hEE, dash = 8'h02, blank = 8'h00; dp always 0.
- Transfer occurs when wr_valid && wr_ready on a rising edge.
- FSM states: IDLE, LOAD, STATIC, SCROLL.
  - IDLE: wr_ready = 1; outputs blank. Transfer writes buf[0], msg_len ← 1, → LOAD. commit ignored.
  - LOAD: wr_ready = (msg_len < MSG_DEPTH); outputs blank. Transfer appends at buf[msg_len]. commit → STATIC if msg_len ≤ 8, else SCROLL with offset ← 0 and step counter ← 0.
  - STATIC: wr_ready = 0; digit k from left (k = 0..7) shows buf[k] if k < msg_len else blank.
  - SCROLL: wr_ready = 0; virtual length V = msg_len + 8 (eight trailing blanks); digit k shows buf[(offset+k) mod V] if that index < msg_len, else blank. Each step, offset ← offset+1, wrapping from V−1 to 0.
- clr in any state → IDLE, msg_len ← 0, offset ← 0; highest priority over wr_valid and commit (a concurrent write is dropped).
- Transfer and commit in the same LOAD cycle: character is stored first; the state decision uses the incremented length.
- Writes while full are not accepted (wr_ready low); commit still works.
- rst_n low: identical to clr, and all outputs forced to reset values.

## Timing

- Reset values: wr_ready 0 during reset, 1 the cycle after release; msg_len 0; showing 0; data7..data0 8'h00.
- data outputs are registered: reflect state/buffer/offset one cycle after they change (commit at edge N → patterns valid after edge N+1).
- First scroll step SCROLL_DIV cycles after entering SCROLL; then every SCROLL_DIV cycles.
- clr at edge N → outputs blank after edge N+1.

## Configuration

- TUB_BLINK_EN defined: adds input blink (1 bit) and parameter BLINK_DIV (default 50_000_000). In STATIC/SCROLL with blink high, outputs alternate between the normal patterns and all-blank every BLINK_DIV cycles, starting visible; the blink counter resets when blink is low. Scrolling continues while blanked.
- Not defined: no blink port, no blink counter; behaviour exactly as above.

## Structure

- Package tub_pkg: state enum, character code constants (CH_BLANK = 36, CH_DASH = 37, CH_UNDER = 38), segment constants (SEG_BLANK, SEG_DASH), and the code→segment function's table.
- Sub-module tub_char_decoder: combinational CHAR_W → NUM_TUBS lookup, instantiated eight times; all sequential logic stays in tub_text_scroller.

## Test plan

- Reset, SCROLL_DIV = 4: write codes 1,2,3, commit → STATIC; data7 = 8'h60, data6 = '2', data5 = '3', data4..data0 = 8'h00; showing = 1, wr_ready = 0.
- Write 10 chars (0..9), commit → data7..data0 = '0'..'7'; after 4 cycles '1'..'8'; after 18 steps (V = 18) back to '0'..'7'.
- Write 32 chars with wr_valid held high on cycle 33 → wr_ready = 0, msg_len = 32, 33rd char not stored.
- In LOAD with msg_len = 8, transfer and commit in the same cycle → msg_len = 9, enters SCROLL.
- clr asserted mid-scroll together with wr_valid → next cycle IDLE, msg_len = 0, outputs 8'h00 after one more edge, write discarded.
- rst_n low for one cycle while in SCROLL → all outputs reset values; subsequent write + commit behaves as from power-up.
